// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared state encoding and baud constants for the UART receiver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned DEF_BAUD_DIV      = 2604;
  // Used by the fullchip fast_sim build.
  localparam int unsigned FAST_SIM_BAUD_DIV = 16;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchronizer; both stages take RESET_VAL while rst is high.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
  parameter int unsigned          WIDTH     = 1,
  parameter logic [WIDTH-1:0]     RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Brief   : 8N1 receiver with sticky ready, framing-error pulse and overrun flag.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DEF_BAUD_DIV,
  parameter int unsigned HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam logic [15:0] C_BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [15:0] C_HALF_RELOAD = 16'(HALF_DIV - 1);

  logic       rx_s;
  logic       rx_q;
  logic [1:0] flush_q, flush_d;
  logic       armed_q, armed_d;
  rx_state_t  state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rdy_q, rdy_d;
  logic       frm_err_q, frm_err_d;
  logic       ovr_q, ovr_d;
  logic       w_fall;
  logic       w_baud_zero;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_rx (
    .clk (clk),
    .rst (rst),
    .d   (RX),
    .q   (rx_s)
  );

  // The preset synchronizer value is not a real observation of the line, so
  // edges are only accepted once RX has been genuinely seen high after reset.
  assign w_fall      = armed_q & rx_q & ~rx_s;
  assign w_baud_zero = (baud_cnt_q == 16'd0);

  always_comb begin
    flush_d    = {flush_q[0], 1'b1};
    armed_d    = armed_q | (flush_q[1] & rx_s);
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = rdy_q;
    ovr_d      = ovr_q;
    frm_err_d  = 1'b0;

    if (clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        baud_cnt_d = 16'd0;
        if (w_fall) begin
          state_d    = START;
          baud_cnt_d = C_HALF_RELOAD;
        end
      end
      START: begin
        if (!w_baud_zero) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          state_d    = DATA;
          baud_cnt_d = C_BAUD_RELOAD;
          bit_cnt_d  = 3'd0;
        end
      end
      DATA: begin
        if (!w_baud_zero) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else begin
          shift_d    = {rx_s, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          baud_cnt_d = C_BAUD_RELOAD;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!w_baud_zero) begin
          baud_cnt_d = baud_cnt_q - 16'd1;
        end else begin
          state_d = IDLE;
          if (rx_s) begin
            // A completing byte overrides a simultaneous acknowledge.
            rx_data_d = shift_q;
            rdy_d     = 1'b1;
            ovr_d     = (rdy_q | ovr_q) & ~clr_rdy;
          end else begin
            frm_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        baud_cnt_d = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_q       <= 1'b1;
      flush_q    <= 2'b00;
      armed_q    <= 1'b0;
      state_q    <= IDLE;
      baud_cnt_q <= 16'd0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rdy_q      <= 1'b0;
      frm_err_q  <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      rx_q       <= rx_s;
      flush_q    <= flush_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
      frm_err_q  <= frm_err_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;
  assign frm_err = frm_err_q;
  assign ovr     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module  : tb_uart_rx
// Brief   : Self-checking bench for uart_rx at BAUD_DIV = 16.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int unsigned C_BAUD = 16;
  localparam int          C_DONE = 154;  // frame cycle whose edge completes the byte

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       RX = 1'b1;
  logic       clr_rdy = 1'b0;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frm_err;
  logic       ovr;

  int cyc = 0;
  int frm_cnt = 0;
  int rise_cyc = 0;
  logic rdy_prev = 1'b0;
  int vectors = 0;
  int errors = 0;

  uart_rx #(.BAUD_DIV(C_BAUD)) dut (
    .clk     (clk),
    .rst     (rst),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy),
    .frm_err (frm_err),
    .ovr     (ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frm_err) frm_cnt <= frm_cnt + 1;
    if (rdy && !rdy_prev) rise_cyc <= cyc;
    rdy_prev <= rdy;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         clr_at;
    logic [7:0] exp_data;
    logic       exp_rdy;
    logic       exp_ovr;
    int         exp_frm;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    vectors++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame cycle k*16+i is the cycle ending on the i-th edge of bit k.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int clr_at,
                            output int t0);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      RX = bits[k];
      for (int i = 0; i < 16; i++) begin
        clr_rdy = ((k * 16 + i) == clr_at);
        tick(1);
      end
    end
    clr_rdy = 1'b0;
    if (!stop) begin
      RX = 1'b1;
      tick(20);
    end
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int frm0);
    chk({tag, " rx_data"}, int'(rx_data), int'(v.exp_data));
    chk({tag, " rdy"}, int'(rdy), int'(v.exp_rdy));
    chk({tag, " ovr"}, int'(ovr), int'(v.exp_ovr));
    chk({tag, " frm_err pulses"}, frm_cnt - frm0, v.exp_frm);
  endtask

  initial begin
    int t0;
    int f0;
    int rise0;
    logic [7:0] m_data;
    logic       m_rdy;
    logic       m_ovr;
    vec_t v;

    tbl[0] = '{8'h00, 1'b1, -1,     8'h00, 1'b1, 1'b0, 0};
    tbl[1] = '{8'hFF, 1'b1, 20,     8'hFF, 1'b1, 1'b0, 0};
    tbl[2] = '{8'h5A, 1'b0, 20,     8'hFF, 1'b0, 1'b0, 1};
    tbl[3] = '{8'h3C, 1'b1, -1,     8'h3C, 1'b1, 1'b0, 0};
    tbl[4] = '{8'h11, 1'b1, 20,     8'h11, 1'b1, 1'b0, 0};
    tbl[5] = '{8'h22, 1'b1, -1,     8'h22, 1'b1, 1'b1, 0};
    tbl[6] = '{8'h33, 1'b1, C_DONE, 8'h33, 1'b1, 1'b0, 0};
    tbl[7] = '{8'h44, 1'b1, C_DONE, 8'h44, 1'b1, 1'b0, 0};
    tbl[8] = '{8'h55, 1'b1, 157,    8'h55, 1'b0, 1'b0, 0};
    tbl[9] = '{8'h66, 1'b1, -1,     8'h66, 1'b1, 1'b0, 0};

    // Reset state
    tick(3);
    chk("reset rx_data", int'(rx_data), 0);
    chk("reset rdy", int'(rdy), 0);
    chk("reset frm_err", int'(frm_err), 0);
    chk("reset ovr", int'(ovr), 0);
    rst = 1'b0;
    tick(5);

    // Single byte with latency and acknowledge
    f0 = frm_cnt;
    send_frame(8'hA5, 1'b1, -1, t0);
    chk_rng("A5 latency", rise_cyc - t0, 154, 156);
    v = '{8'hA5, 1'b1, -1, 8'hA5, 1'b1, 1'b0, 0};
    check_frame("A5", v, f0);
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
    chk("A5 clr rdy", int'(rdy), 0);
    chk("A5 clr rx_data", int'(rx_data), 8'hA5);

    // Directed frame table, sent back-to-back
    for (int n = 0; n < 10; n++) begin
      f0 = frm_cnt;
      send_frame(tbl[n].data, tbl[n].stop, tbl[n].clr_at, t0);
      check_frame($sformatf("vec%0d", n), tbl[n], f0);
      if (n == 0) rise0 = rise_cyc;
      if (n == 1) chk("back-to-back rdy spacing", rise_cyc - rise0, 160);
    end

    // False start: short low pulse must be ignored
    f0 = frm_cnt;
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    tick(30);
    chk("false start rdy", int'(rdy), 1);
    chk("false start rx_data", int'(rx_data), 8'h66);
    chk("false start frm_err", frm_cnt - f0, 0);
    send_frame(8'h3C, 1'b1, 20, t0);
    chk("after false start rx_data", int'(rx_data), 8'h3C);
    chk("after false start rdy", int'(rdy), 1);

    // Reset during data bit 3 with RX low
    RX = 1'b0;
    tick(16);
    RX = 1'b1;
    tick(48);
    RX = 1'b0;
    tick(8);
    rst = 1'b1;
    #1;
    chk("midreset rx_data", int'(rx_data), 0);
    chk("midreset rdy", int'(rdy), 0);
    chk("midreset ovr", int'(ovr), 0);
    chk("midreset frm_err", int'(frm_err), 0);
    tick(2);
    rst = 1'b0;
    f0 = frm_cnt;
    tick(200);
    chk("low after reset rdy", int'(rdy), 0);
    chk("low after reset frm_err", frm_cnt - f0, 0);
    RX = 1'b1;
    tick(20);
    send_frame(8'hC3, 1'b1, -1, t0);
    chk("after reset rx_data", int'(rx_data), 8'hC3);
    chk("after reset rdy", int'(rdy), 1);
    chk("after reset ovr", int'(ovr), 0);

    // Randomised frames against an event-ordered reference model
    m_data = 8'hC3;
    m_rdy  = 1'b1;
    m_ovr  = 1'b0;
    for (int r = 0; r < 30; r++) begin
      int sel;
      v.data   = 8'($urandom);
      v.stop   = ($urandom_range(0, 9) != 0);
      sel      = $urandom_range(0, 3);
      v.clr_at = (sel == 0) ? -1 :
                 (sel == 1) ? $urandom_range(0, C_DONE - 1) :
                 (sel == 2) ? C_DONE : $urandom_range(C_DONE + 1, 159);
      if (v.clr_at >= 0 && v.clr_at < C_DONE) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
      if (v.stop) begin
        m_ovr  = m_rdy && (v.clr_at != C_DONE);
        m_rdy  = 1'b1;
        m_data = v.data;
        v.exp_frm = 0;
      end else begin
        v.exp_frm = 1;
        if (v.clr_at == C_DONE) begin
          m_rdy = 1'b0;
          m_ovr = 1'b0;
        end
      end
      if (v.clr_at > C_DONE) begin
        m_rdy = 1'b0;
        m_ovr = 1'b0;
      end
      v.exp_data = m_data;
      v.exp_rdy  = m_rdy;
      v.exp_ovr  = m_ovr;
      f0 = frm_cnt;
      send_frame(v.data, v.stop, v.clr_at, t0);
      check_frame($sformatf("rnd%0d", r), v, f0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
